// File: rtl/print_clear_sequencer_if.sv
// Avalon-MM register-slave bus for the print-clear sequencer.
// Latency: readdata is combinational from address, zero wait states.
// Backpressure: none; every access completes in the cycle it is presented.
interface print_clear_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/print_clear_sequencer.sv
// Turns each print-clear request edge into one timed active-low clear pulse plus hold-off window.
// Latency: prn_clr_n falls one clock after the request edge and stays low PULSE_CYCLES clocks.
// Backpressure: none; requests arriving while busy are dropped and flagged as overrun.
module print_clear_sequencer #(
    parameter int PULSE_CYCLES   = 50,
    parameter int HOLDOFF_CYCLES = 500,
    parameter int CNT_W          = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clear_req,
    print_clear_sequencer_if.slave      bus,
    output logic                        prn_clr_n,
    output logic                        busy,
    output logic                        irq
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    // Counter reload values: counting down to zero inclusive gives N cycles per phase.
    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               complete;

    logic               clear_req_d;
    logic               hw_start;
    logic               sw_start;
    logic               start;
    logic               wr;

    logic               done;
    logic               overrun;
    logic               irq_en;
    logic [15:0]        clr_count;

    // Only bits 2:0 of writedata are meaningful in any register.
    wire unused_wdata = &{1'b0, bus.writedata[31:3], 1'b0};

    assign wr       = bus.chipselect & ~bus.write_n;
    assign hw_start = clear_req & ~clear_req_d;
    assign sw_start = wr & (bus.address == 2'd3) & bus.writedata[0];
    // A hardware edge and a soft trigger in the same cycle are one request.
    assign start    = hw_start | sw_start;

    // Outputs decode straight from the state register so reset releases them without a clock.
    assign prn_clr_n = ~(state_q == ASSERT);
    assign busy      = (state_q != IDLE);
    assign irq       = done & irq_en;

    // Registered copy of the request level for rising-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clear_req_d <= 1'b0;
        end else begin
            clear_req_d <= clear_req;
        end
    end

    // FSM state and timing counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: pulse phase, then hold-off phase, each timed by the down-counter.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = PULSE_LOAD;
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d   = HOLDOFF_LOAD;
                    state_d = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d  = IDLE;
                    complete = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Status flags: hardware set takes priority over a same-cycle write-one-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (complete) begin
                done <= 1'b1;
            end else if (wr && bus.address == 2'd0 && bus.writedata[1]) begin
                done <= 1'b0;
            end
            if (start && state_q != IDLE) begin
                overrun <= 1'b1;
            end else if (wr && bus.address == 2'd0 && bus.writedata[2]) begin
                overrun <= 1'b0;
            end
        end
    end

    // Interrupt enable and completion counter; a COUNT write beats a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en    <= 1'b0;
            clr_count <= 16'd0;
        end else begin
            if (wr && bus.address == 2'd1) begin
                irq_en <= bus.writedata[0];
            end
            if (wr && bus.address == 2'd2) begin
                clr_count <= 16'd0;
            end else if (complete) begin
                clr_count <= clr_count + 16'd1;
            end
        end
    end

    // Zero-wait-state read mux; unused bits and TRIGGER read as zero.
    always_comb begin
        bus.readdata = 32'd0;
        case (bus.address)
            2'd0:    bus.readdata = {29'd0, overrun, done, busy};
            2'd1:    bus.readdata = {31'd0, irq_en};
            2'd2:    bus.readdata = {16'd0, clr_count};
            default: bus.readdata = 32'd0;
        endcase
    end

endmodule

// File: doc/print_clear_sequencer.md
Name: print_clear_sequencer

Overview:
- Consumes the 1-bit print-clear level from the HPS-side Avalon PIO and turns each rising edge into one timed, active-low clear pulse to the printer head interface, followed by a hold-off window.
- Exposes status, interrupt enable, a soft trigger and a completion counter over a small Avalon-MM slave on the same lightweight bridge.
- Sits directly downstream of the print-clear PIO and on the same clock.

Parameters:
- PULSE_CYCLES, 50, clocks prn_clr_n is held low (1 us at 50 MHz); legal range 1..2^CNT_W-1.
- HOLDOFF_CYCLES, 500, clocks of quiet time after the pulse before a new request is accepted; legal range 1..2^CNT_W-1.
- CNT_W, 16, width of the internal timing counter.

Ports:
- clk  in  1  system clock, shared with the PIO.
- reset_n  in  1  asynchronous, active-low reset.
- clear_req  in  1  level from the PIO out_port; synchronous to clk.
- address  in  2  Avalon-MM word address.
- chipselect  in  1  Avalon-MM select.
- write_n  in  1  Avalon-MM write strobe, active-low.
- writedata  in  32  Avalon-MM write data.
- readdata  out  32  Avalon-MM read data, combinational from address, zero wait states.
- prn_clr_n  out  1  active-low clear strobe to the printer interface.
- busy  out  1  high while not IDLE.
- irq  out  1  level interrupt, equal to done AND irq_en.

Behaviour:
- Reset, asynchronous on reset_n low:
  - State IDLE, timing counter 0, clear_req_d 0.
  - done, overrun and irq_en all 0; clr_count 0.
  - prn_clr_n=1, busy=0, irq=0.
  - Reset takes effect immediately, including mid-pulse: prn_clr_n returns to 1 without waiting for a clock.
- Edge detect:
  - clear_req_d is clear_req registered.
  - hw_start = clear_req & ~clear_req_d.
  - A held-high level never retriggers; a new edge needs a low level for at least 1 cycle first.
- Soft trigger: a write to address 3 with writedata[0]=1 produces sw_start for that one cycle.
- start = hw_start | sw_start. If both occur in the same cycle, they count as one request.
- FSM states and transitions:
  - IDLE: on start, load counter = PULSE_CYCLES-1 and go to ASSERT.
  - ASSERT: while counter>0, decrement. At 0, load counter = HOLDOFF_CYCLES-1 and go to HOLDOFF.
  - HOLDOFF: while counter>0, decrement. At 0, go to IDLE, set done, and clr_count <= clr_count+1. The counter is 16 bits and wraps from 0xFFFF to 0x0000.
- Timing:
  - prn_clr_n = ~(state==ASSERT).
  - If start is sampled at edge E, prn_clr_n is low from E to E+PULSE_CYCLES, i.e. exactly PULSE_CYCLES cycles.
  - busy is high for PULSE_CYCLES+HOLDOFF_CYCLES cycles.
  - done rises at the same edge busy falls.
- Overrun: start while state is not IDLE sets overrun, and the request is dropped (not queued).
- Register map. Reads return 0 in unused bits; unmapped write bits are ignored.
  - addr 0, STATUS: bit0 busy (RO), bit1 done (W1C), bit2 overrun (W1C).
  - addr 1, CONTROL: bit0 irq_en (RW).
  - addr 2, COUNT: bits15:0 clr_count (RO). A write clears it to 0.
  - addr 3, TRIGGER: write-only, reads 0.
- Simultaneous events:
  - A hardware set of done or overrun wins over a W1C in the same cycle.
  - A COUNT write in the same cycle as an increment leaves the count at 0.
- A write occurs only when chipselect=1 and write_n=0. Reads have no side effects.

Test Plan:
- Parameters PULSE_CYCLES=4, HOLDOFF_CYCLES=6, clear_req 0->1 -> prn_clr_n low for exactly 4 cycles; busy high for 10 cycles; then STATUS=0x2 and COUNT=1.
- clear_req held high for 50 cycles -> exactly one pulse and COUNT=1. Toggle low for 1 cycle then high -> a second pulse and COUNT=2.
- Second clear_req edge 3 cycles into HOLDOFF -> no extra pulse; STATUS bit2=1. Write 0x6 to addr 0 -> STATUS=0x0.
- CONTROL=1, pulse completes -> irq=1. Write 0x2 to addr 0 in the same cycle a new done is set -> done stays 1 and irq stays 1.
- Write 0x1 to addr 3 in the same cycle as a hw_start -> a single 4-cycle pulse, COUNT increments by 1, and overrun stays 0.
- Assert reset_n low during cycle 2 of ASSERT -> prn_clr_n=1 and busy=0 immediately; after release, STATUS=0 and COUNT=0. Also preload 0xFFFF completions -> the next completion reads COUNT=0x0000.
